// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: aligns and formats RV32I loads/stores and runs a
// req/gnt/rvalid handshake on the data bus, stalling the pipeline until completion.
module mem_lsu #(
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_rs2_data,
  output logic [31:0] mem_mem_read_data,
  output logic        mem_stall,
  output logic        access_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [CntW-1:0] r_cnt;
  logic        r_req, r_we, r_bus_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_access, w_illegal, w_legal, w_timeout, w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_load_data;

  assign w_access = ex_mem_mem_read | ex_mem_mem_write;
  assign w_legal  = w_access & ~w_illegal;
  assign w_timeout = (r_cnt == CntMax);
  // Timeout fires only when the awaited handshake did not arrive this cycle.
  assign w_abort  = w_timeout & (((r_state == StReq) & ~dbus_gnt) |
                                 ((r_state == StResp) & ~dbus_rvalid));

  // Decode funct3/alignment into a legality flag; unsigned sizes are loads only.
  always_comb begin
    w_illegal = 1'b0;
    case (ex_mem_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b100:  w_illegal = ex_mem_mem_write;
      3'b001:  w_illegal = ex_mem_alu_result[0];
      3'b101:  w_illegal = ex_mem_alu_result[0] | ex_mem_mem_write;
      3'b010:  w_illegal = (ex_mem_alu_result[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  // Build byte enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (ex_mem_mem_write) begin
      case (ex_mem_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ex_mem_alu_result[1:0];
          w_wdata = {4{ex_mem_rs2_data[7:0]}};
        end
        2'b01: begin
          w_be    = ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ex_mem_rs2_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_mem_rs2_data;
        end
      endcase
    end
  end

  // Extract and extend the addressed byte/half from the returned word.
  always_comb begin
    w_shifted = dbus_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_legal) w_state_next = StReq;
      StReq: begin
        if (dbus_gnt)       w_state_next = r_we ? StDone : StResp;
        else if (w_timeout) w_state_next = StDone;
      end
      StResp: if (dbus_rvalid || w_timeout) w_state_next = StDone;
      StDone: w_state_next = StIdle;
    endcase
  end

  // Combinational outputs; held quiet while reset is asserted.
  always_comb begin
    mem_stall  = rstn & ((r_state == StReq) | (r_state == StResp) |
                         ((r_state == StIdle) & w_legal));
    access_err = rstn & (r_state == StIdle) & w_access & w_illegal;
  end

  // Handshake timer, restarted on every entry to REQ and RESP.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if ((r_state == StIdle) || (r_state == StDone) ||
                 ((r_state == StReq) && dbus_gnt)) begin
      r_cnt <= '0;
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Bus request registers, load result and error pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 32'h0;
      r_be      <= 4'h0;
      r_wdata   <= 32'h0;
      r_funct3  <= 3'h0;
      r_off     <= 2'h0;
      r_rdata   <= 32'h0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
      if (w_abort) r_rdata <= 32'h0;
      unique case (r_state)
        StIdle: begin
          if (w_legal) begin
            r_req    <= 1'b1;
            r_we     <= ex_mem_mem_write;
            r_addr   <= {ex_mem_alu_result[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= ex_mem_funct3;
            r_off    <= ex_mem_alu_result[1:0];
          end else if (ex_mem_mem_read && !ex_mem_mem_write) begin
            r_rdata <= 32'h0;
          end
        end
        StReq:  if (dbus_gnt || w_timeout) r_req <= 1'b0;
        StResp: if (dbus_rvalid) r_rdata <= w_load_data;
        StDone: ;
      endcase
    end
  end

  assign dbus_req          = r_req;
  assign dbus_we           = r_we;
  assign dbus_addr         = r_addr;
  assign dbus_be           = r_be;
  assign dbus_wdata        = r_wdata;
  assign mem_mem_read_data = r_rdata;
  assign bus_err           = r_bus_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: scoreboarded bus transactions and load results.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data;
  logic [31:0] mem_mem_read_data;
  logic        mem_stall, access_err, bus_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] exp_rd_q[$];

  mem_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rs2_data   (ex_mem_rs2_data),
    .mem_mem_read_data (mem_mem_read_data),
    .mem_stall         (mem_stall),
    .access_err        (access_err),
    .bus_err           (bus_err),
    .dbus_req          (dbus_req),
    .dbus_we           (dbus_we),
    .dbus_addr         (dbus_addr),
    .dbus_be           (dbus_be),
    .dbus_wdata        (dbus_wdata),
    .dbus_gnt          (dbus_gnt),
    .dbus_rvalid       (dbus_rvalid),
    .dbus_rdata        (dbus_rdata)
  );

  always #5 clk = ~clk;

  // Bus monitor: every granted request is matched against the expected queue.
  always @(negedge clk) begin : mon
    txn_t t;
    if (rstn === 1'b1 && dbus_req === 1'b1 && dbus_gnt === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_txn unexpected: we=%b addr=%h be=%b", dbus_we, dbus_addr, dbus_be);
      end else begin
        t = exp_q.pop_front();
        if (dbus_we !== t.we || dbus_addr !== t.addr || dbus_be !== t.be ||
            (t.we && dbus_wdata !== t.wdata)) begin
          errors++;
          $display("FAIL bus_txn got we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                   dbus_we, dbus_addr, dbus_be, dbus_wdata, t.we, t.addr, t.be, t.wdata);
        end
      end
    end
  end

  // Drives one legal access from IDLE and acts as bus slave; entered and left at posedge+1.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                            output int stall_cyc, output int req_cyc, output int berr_cyc,
                            output logic [31:0] data, output logic ok);
    int gcnt = 0;
    int rcnt = 0;
    bit granted = 0;
    bit got_rv = 0;
    logic prev = 1'b0;
    stall_cyc = 0; req_cyc = 0; berr_cyc = 0; data = 32'h0; ok = 1'b0;
    ex_mem_mem_read = rd; ex_mem_mem_write = wr; ex_mem_funct3 = f3;
    ex_mem_alu_result = addr; ex_mem_rs2_data = rs2;
    for (int c = 0; c < 60; c++) begin
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
      if (dbus_req && !granted) begin
        if (gcnt >= gnt_dly) dbus_gnt = 1'b1;
        gcnt++;
      end else if (granted && rd && !wr && !got_rv) begin
        if (rcnt >= rv_dly) begin
          dbus_rvalid = 1'b1; dbus_rdata = rdata; got_rv = 1;
        end
        rcnt++;
      end
      @(negedge clk);
      if (dbus_gnt && dbus_req) granted = 1;
      stall_cyc += int'(mem_stall);
      req_cyc   += int'(dbus_req);
      berr_cyc  += int'(bus_err);
      if (prev && !mem_stall) begin
        data = mem_mem_read_data;
        ok = 1'b1;
      end
      prev = mem_stall;
      @(posedge clk); #1;
      if (ok) break;
    end
    ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0; ex_mem_funct3 = 3'b010;
    ex_mem_alu_result = 32'h100; ex_mem_rs2_data = 32'h55;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dbus_req, dbus_we, dbus_be} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got req=%b we=%b be=%b want 0", dbus_req, dbus_we, dbus_be);
    end
    checks++;
    if ({dbus_addr, dbus_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_bus got addr=%h wdata=%h want 0", dbus_addr, dbus_wdata);
    end
    checks++;
    if (mem_mem_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", mem_mem_read_data);
    end
    checks++;
    if ({mem_stall, access_err, bus_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got stall=%b aerr=%b berr=%b want 0", mem_stall, access_err, bus_err);
    end
    @(posedge clk); #1;
    rstn = 1'b1; ex_mem_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got stall=%b req=%b want 0", mem_stall, dbus_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int sc, rc, bc;
    logic [31:0] d, e;
    logic ok;
    exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0});
    exp_rd_q.push_back(32'hDEADBEEF);
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, sc, rc, bc, d, ok);
    e = exp_rd_q.pop_front();
    checks++;
    if (ok !== 1'b1 || d !== e) begin
      errors++; $display("FAIL lw_data got %h (done=%b) want %h", d, ok, e);
    end
    checks++;
    if (sc != 3 || rc != 1 || bc != 0) begin
      errors++; $display("FAIL lw_timing got stall=%0d req=%0d berr=%0d want 3 1 0", sc, rc, bc);
    end
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL lw_idle_stall got %b want 0", mem_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    int sc, rc, bc;
    logic [31:0] d, e;
    logic ok;
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h103, 32'h103, 32'h102, 32'h102};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F0, 32'h000080F0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0});
      exp_rd_q.push_back(exps[i]);
      run_access(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 0, 0, 32'h80F07F01, sc, rc, bc, d, ok);
      e = exp_rd_q.pop_front();
      checks++;
      if (ok !== 1'b1 || d !== e || sc != 3) begin
        errors++;
        $display("FAIL load_fmt f3=%b addr=%h got %h stall=%0d want %h stall=3",
                 f3s[i], adrs[i], d, sc, e);
      end
    end
  endtask

  task automatic test_sb_delayed();
    int sc, rc, bc;
    logic [31:0] d;
    logic ok;
    exp_q.push_back('{we: 1'b1, addr: 32'h200, be: 4'b0010, wdata: 32'hABABABAB});
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000AB, 3, 0, 32'h0, sc, rc, bc, d, ok);
    checks++;
    if (ok !== 1'b1 || sc != 5 || rc != 4) begin
      errors++; $display("FAIL sb_timing got stall=%0d req=%0d done=%b want 5 4 1", sc, rc, ok);
    end
    checks++;
    if (d !== 32'h000080F0) begin
      errors++; $display("FAIL sb_data_hold got %h want 000080f0", d);
    end
  endtask

  task automatic test_illegal();
    logic        rds [4];
    logic [2:0]  f3s [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    rds  = '{1'b0, 1'b0, 1'b1, 1'b1};
    f3s  = '{3'b001, 3'b100, 3'b010, 3'b001};
    adrs = '{32'h301, 32'h300, 32'h102, 32'h105};
    exps = '{32'h000080F0, 32'h000080F0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      ex_mem_mem_read = rds[i]; ex_mem_mem_write = ~rds[i];
      ex_mem_funct3 = f3s[i]; ex_mem_alu_result = adrs[i]; ex_mem_rs2_data = 32'h1234;
      @(negedge clk);
      checks++;
      if (access_err !== 1'b1 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL illegal_flag f3=%b addr=%h got aerr=%b stall=%b want 1 0",
                 f3s[i], adrs[i], access_err, mem_stall);
      end
      @(posedge clk); #1;
      ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
      @(negedge clk);
      checks++;
      if (dbus_req !== 1'b0 || access_err !== 1'b0 || mem_mem_read_data !== exps[i]) begin
        errors++;
        $display("FAIL illegal_after f3=%b got req=%b aerr=%b data=%h want 0 0 %h",
                 f3s[i], dbus_req, access_err, mem_mem_read_data, exps[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int sc, rc, bc;
    logic [31:0] d, e;
    logic ok;
    exp_q.push_back('{we: 1'b1, addr: 32'h40, be: 4'b1111, wdata: 32'h12345678});
    run_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678, 1, 0, 32'h0, sc, rc, bc, d, ok);
    checks++;
    if (ok !== 1'b1 || sc != 3 || rc != 2) begin
      errors++; $display("FAIL b2b_sw got stall=%0d req=%0d done=%b want 3 2 1", sc, rc, ok);
    end
    exp_q.push_back('{we: 1'b0, addr: 32'h44, be: 4'b1111, wdata: 32'h0});
    exp_rd_q.push_back(32'h00007ABC);
    run_access(1'b1, 1'b0, 3'b001, 32'h46, 32'h0, 0, 2, 32'h7ABC1234, sc, rc, bc, d, ok);
    e = exp_rd_q.pop_front();
    checks++;
    if (ok !== 1'b1 || d !== e || sc != 5) begin
      errors++; $display("FAIL b2b_lh got %h stall=%0d want %h stall=5", d, sc, e);
    end
  endtask

  task automatic test_timeout();
    int sc, rc, bc;
    logic [31:0] d, e;
    logic ok;
    exp_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0});
    exp_rd_q.push_back(32'h0);
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 1000, 32'hFFFFFFFF, sc, rc, bc, d, ok);
    e = exp_rd_q.pop_front();
    checks++;
    if (ok !== 1'b1 || d !== e) begin
      errors++; $display("FAIL timeout_data got %h (done=%b) want %h", d, ok, e);
    end
    checks++;
    if (bc != 1 || sc != 6) begin
      errors++; $display("FAIL timeout_pulse got berr=%0d stall=%0d want 1 6", bc, sc);
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got berr=%b stall=%b req=%b want 0", bus_err, mem_stall, dbus_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_req();
    ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0; ex_mem_funct3 = 3'b010;
    ex_mem_alu_result = 32'h180; ex_mem_rs2_data = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h180) begin
      errors++; $display("FAIL midreq_start got req=%b addr=%h want 1 00000180", dbus_req, dbus_addr);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL midreq_reset got req=%b stall=%b want 0 0", dbus_req, mem_stall);
    end
    rstn = 1'b1; ex_mem_mem_read = 1'b0;
    @(posedge clk); #1;
    // Stray handshake while idle must be ignored.
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_mem_read_data !== 32'h0 || dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got data=%h req=%b stall=%b want 0 0 0",
               mem_mem_read_data, dbus_req, mem_stall);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_format();
    test_sb_delayed();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL txn_missing got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
